yuv422_upsample_csc_stream: RTL and testbench

//  Streaming successor of the milestone-1 colourspace datapath. Accepts one Y pair plus
//  one U/V sample per cycle (4:2:2 rows) and rebuilds odd-column chroma with the 6-tap
//  FIR (21,-52,159,159,-52,21). Converts each pixel pair to RGB888 and emits it on a

---
 rtl/yuv422_upsample_csc_stream.sv | 205 ++++++++++++++++++++
 tb/tb_yuv422_upsample_csc_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/yuv422_upsample_csc_stream.sv
// yuv422_upsample_csc_stream: 4:2:2 row chroma upsampler (6-tap FIR) plus YUV->RGB888 on a valid/ready stream.
// Optional build macro CSC_ROUND_EN: round the CSC sums half-up instead of truncating.
module yuv422_upsample_csc_stream #(
    parameter int ROW_WIDTH = 320,
    parameter int CNT_W     = $clog2(ROW_WIDTH / 2)
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_y,
    input  logic [7:0]  in_u,
    input  logic [7:0]  in_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb_even,
    output logic [23:0] out_rgb_odd,
    output logic        out_last
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_WIDTH / 2 - 1);
`ifdef CSC_ROUND_EN
    localparam logic signed [31:0] RND = 32'sd32768;
`else
    localparam logic signed [31:0] RND = 32'sd0;
`endif

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, icnt_q;
    logic [7:0]         wu_q [6];
    logic [7:0]         wv_q [6];
    logic [15:0]        yl_q [4];
    logic               win_q;
    logic signed [9:0]  p1_y_q [2];
    logic signed [9:0]  p1_u_q [2];
    logic signed [9:0]  p1_v_q [2];
    logic               p1_vld_q, p1_last_q;
    logic signed [31:0] p2_yk_q [2];
    logic signed [31:0] p2_rv_q [2];
    logic signed [31:0] p2_gu_q [2];
    logic signed [31:0] p2_gv_q [2];
    logic signed [31:0] p2_bu_q [2];
    logic               p2_vld_q, p2_last_q;
    logic               advance, accept, flush_adv, first;

    function automatic logic signed [31:0] sx(input logic [7:0] x);
        return $signed({24'd0, x});
    endfunction

    function automatic logic [7:0] fir6(input logic [7:0] a, b, c, d, e, f);
        logic signed [31:0] s;
        s = (32'sd21 * (sx(a) + sx(f)) - 32'sd52 * (sx(b) + sx(e))
             + 32'sd159 * (sx(c) + sx(d)) + 32'sd128) >>> 8;
        return s < 32'sd0 ? 8'd0 : s > 32'sd255 ? 8'd255 : s[7:0];
    endfunction

    function automatic logic signed [9:0] off(input logic [7:0] x, input logic [7:0] k);
        return $signed({2'b00, x}) - $signed({2'b00, k});
    endfunction

    function automatic logic signed [31:0] ext(input logic signed [9:0] x);
        return {{22{x[9]}}, x};
    endfunction

    function automatic logic [7:0] clip(input logic signed [31:0] s);
        logic signed [31:0] t;
        t = s >>> 16;
        return s < 32'sd0 ? 8'd0 : t > 32'sd255 ? 8'd255 : s[23:16];
    endfunction

    function automatic logic [23:0] csc(input logic signed [31:0] yk, rv, gu, gv, bu);
        return {clip(yk + rv + RND), clip(yk - gu - gv + RND), clip(yk + bu + RND)};
    endfunction

    assign advance   = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign flush_adv = advance && state_q == S_FLUSH;
    assign first     = accept && cnt_q == '0;

    // State register; cnt_q counts accepted pairs in FILL/RUN and flush steps in FLUSH
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: four pairs prime the window, the last pair starts a 3-step flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_FLUSH) begin
            if (advance) begin
                cnt_d   = (cnt_q == CNT_W'(2)) ? '0 : cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(2)) ? S_FILL : S_FLUSH;
            end
        end else if (accept) begin
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            state_d = (cnt_q == LAST) ? S_FLUSH : (cnt_q == CNT_W'(3)) ? S_RUN : state_q;
        end
    end

    // Input handshake: no input while flushing, stalled or in reset
    always_comb begin
        in_ready = advance && state_q != S_FLUSH && !Reset;
    end

    // Chroma window and Y delay line; first pair of a row fills the left edge, flush replicates the right edge
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            for (int i = 0; i < 6; i++) begin
                wu_q[i] <= '0;
                wv_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) yl_q[i] <= '0;
            win_q <= 1'b0;
        end else begin
            if (accept || flush_adv) begin
                for (int i = 0; i < 5; i++) begin
                    wu_q[i] <= first ? in_u : wu_q[i+1];
                    wv_q[i] <= first ? in_v : wv_q[i+1];
                end
                wu_q[5] <= accept ? in_u : wu_q[5];
                wv_q[5] <= accept ? in_v : wv_q[5];
                for (int i = 0; i < 3; i++) yl_q[i] <= yl_q[i+1];
                yl_q[3] <= accept ? in_y : yl_q[3];
            end
            if (advance) win_q <= (accept && cnt_q >= CNT_W'(3)) || state_q == S_FLUSH;
        end
    end

    // P1: odd-chroma FIR and offset removal; also tags the row's final output pair
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            p1_vld_q  <= 1'b0;
            p1_last_q <= 1'b0;
            icnt_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                p1_y_q[i] <= '0;
                p1_u_q[i] <= '0;
                p1_v_q[i] <= '0;
            end
        end else if (advance) begin
            p1_vld_q  <= win_q;
            p1_last_q <= icnt_q == LAST;
            if (win_q) begin
                icnt_q    <= (icnt_q == LAST) ? '0 : icnt_q + CNT_W'(1);
                p1_y_q[0] <= off(yl_q[0][15:8], 8'd16);
                p1_y_q[1] <= off(yl_q[0][7:0], 8'd16);
                p1_u_q[0] <= off(wu_q[2], 8'd128);
                p1_v_q[0] <= off(wv_q[2], 8'd128);
                p1_u_q[1] <= off(fir6(wu_q[0], wu_q[1], wu_q[2], wu_q[3], wu_q[4], wu_q[5]), 8'd128);
                p1_v_q[1] <= off(fir6(wv_q[0], wv_q[1], wv_q[2], wv_q[3], wv_q[4], wv_q[5]), 8'd128);
            end
        end
    end

    // P2: CSC coefficient products for both pixels
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            p2_vld_q  <= 1'b0;
            p2_last_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                p2_yk_q[i] <= '0;
                p2_rv_q[i] <= '0;
                p2_gu_q[i] <= '0;
                p2_gv_q[i] <= '0;
                p2_bu_q[i] <= '0;
            end
        end else if (advance) begin
            p2_vld_q  <= p1_vld_q;
            p2_last_q <= p1_last_q;
            if (p1_vld_q) begin
                for (int i = 0; i < 2; i++) begin
                    p2_yk_q[i] <= 32'sd76284 * ext(p1_y_q[i]);
                    p2_rv_q[i] <= 32'sd104595 * ext(p1_v_q[i]);
                    p2_gu_q[i] <= 32'sd25624 * ext(p1_u_q[i]);
                    p2_gv_q[i] <= 32'sd53281 * ext(p1_v_q[i]);
                    p2_bu_q[i] <= 32'sd132251 * ext(p1_u_q[i]);
                end
            end
        end
    end

    // P3: channel sums and clipping into the output register, held while the sink stalls
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_rgb_even <= '0;
            out_rgb_odd  <= '0;
        end else if (advance) begin
            out_valid <= p2_vld_q;
            out_last  <= p2_vld_q && p2_last_q;
            if (p2_vld_q) begin
                out_rgb_even <= csc(p2_yk_q[0], p2_rv_q[0], p2_gu_q[0], p2_gv_q[0], p2_bu_q[0]);
                out_rgb_odd  <= csc(p2_yk_q[1], p2_rv_q[1], p2_gu_q[1], p2_gv_q[1], p2_bu_q[1]);
            end
        end
    end
endmodule

// File: tb/tb_yuv422_upsample_csc_stream.sv
// tb_yuv422_upsample_csc_stream: randomized stream bench with a row-level reference model.
module tb_yuv422_upsample_csc_stream;
    localparam int RW = 320;
    localparam int P  = RW / 2;
    localparam int NR = 10;
`ifdef CSC_ROUND_EN
    localparam int          RND  = 32768;
    localparam logic [23:0] G235 = 24'hFFFFFF;
`else
    localparam int          RND  = 0;
    localparam logic [23:0] G235 = 24'hFEFEFE;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [15:0] in_y;
    logic [7:0]  in_u, in_v;
    logic [23:0] out_rgb_even, out_rgb_odd;

    always #5 clk = ~clk;

    yuv422_upsample_csc_stream #(.ROW_WIDTH(RW)) dut (
        .Clock_50    (clk),
        .Reset       (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_y        (in_y),
        .in_u        (in_u),
        .in_v        (in_v),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rgb_even(out_rgb_even),
        .out_rgb_odd (out_rgb_odd),
        .out_last    (out_last)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] qy[$];
    logic [7:0]  qu[$];
    logic [7:0]  qv[$];
    logic [15:0] ay [NR][P];
    logic [7:0]  au [NR][P];
    logic [7:0]  av [NR][P];
    logic [47:0] got [NR][P];
    int          in_row = 0, in_n = 0, out_row = 0, out_n = 0;
    int          p_in = 100, p_out = 100;
    bit          hold = 1'b0;
    logic [48:0] snap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chroma sample k of a row, with the row edges replicated
    function automatic int cu(int r, int k, bit isv);
        int kk;
        kk = k < 0 ? 0 : k > P - 1 ? P - 1 : k;
        return isv ? int'(av[r][kk]) : int'(au[r][kk]);
    endfunction

    function automatic int fir(int r, int j, bit isv);
        int s;
        s = (21 * cu(r, j - 2, isv) - 52 * cu(r, j - 1, isv) + 159 * cu(r, j, isv)
             + 159 * cu(r, j + 1, isv) - 52 * cu(r, j + 2, isv) + 21 * cu(r, j + 3, isv) + 128) >>> 8;
        return s < 0 ? 0 : s > 255 ? 255 : s;
    endfunction

    function automatic logic [7:0] ch(int s);
        return s < 0 ? 8'd0 : (s / 65536) > 255 ? 8'd255 : 8'(s / 65536);
    endfunction

    function automatic logic [23:0] rgb(int y, int u, int v);
        int yy;
        yy = 76284 * (y - 16);
        return {ch(yy + 104595 * (v - 128) + RND),
                ch(yy - 25624 * (u - 128) - 53281 * (v - 128) + RND),
                ch(yy + 132251 * (u - 128) + RND)};
    endfunction

    function automatic logic [47:0] ref_pair(int r, int j);
        int ye, yo;
        ye = int'(ay[r][j][15:8]);
        yo = int'(ay[r][j][7:0]);
        return {rgb(ye, cu(r, j, 0), cu(r, j, 1)), rgb(yo, fir(r, j, 0), fir(r, j, 1))};
    endfunction

    task automatic load_row(input int kind);
        for (int j = 0; j < P; j++) begin
            case (kind)
                0:       begin qy.push_back(16'h1010); qu.push_back(8'd128); qv.push_back(8'd128); end
                1:       begin qy.push_back(16'hEBEB); qu.push_back(8'd128); qv.push_back(8'd128); end
                2:       begin qy.push_back(16'hFFFF); qu.push_back(8'd255); qv.push_back(8'd255); end
                3:       begin qy.push_back(16'h1010); qu.push_back(j < 12 ? 8'(128 + 10 * j) : 8'd255); qv.push_back(8'd128); end
                4:       begin qy.push_back(16'h1010); qu.push_back(8'd50); qv.push_back(8'd128); end
                5:       begin qy.push_back(16'h1010); qu.push_back(8'd200); qv.push_back(8'd128); end
                default: begin qy.push_back(16'($urandom)); qu.push_back(8'($urandom)); qv.push_back(8'($urandom)); end
            endcase
        end
    endtask

    // One clock: drive at negedge, then score the handshakes that the next posedge will take
    task automatic step();
        bit avail;
        @(negedge clk);
        in_valid  = qy.size() > 0 && $urandom_range(99) < p_in;
        in_y      = in_valid ? qy[0] : '0;
        in_u      = in_valid ? qu[0] : '0;
        in_v      = in_valid ? qv[0] : '0;
        out_ready = !hold && $urandom_range(99) < p_out;
        #1;
        if (out_valid && out_ready) begin
            if (out_row >= NR) begin
                check("extra_output", out_row, NR - 1);
            end else begin
                avail = out_row < in_row || in_n > ((out_n + 3 < P - 1) ? out_n + 3 : P - 1);
                check("order", avail, 1);
                check("pair", {out_rgb_even, out_rgb_odd}, ref_pair(out_row, out_n));
                check("last", out_last, out_n == P - 1);
                got[out_row][out_n] = {out_rgb_even, out_rgb_odd};
                out_n++;
                if (out_n == P) begin
                    out_n = 0;
                    out_row++;
                end
            end
        end
        if (in_valid && in_ready) begin
            ay[in_row][in_n] = qy.pop_front();
            au[in_row][in_n] = qu.pop_front();
            av[in_row][in_n] = qv.pop_front();
            in_n++;
            if (in_n == P) begin
                in_n = 0;
                in_row++;
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 4000 && !(qy.size() == 0 && in_n == 0 && out_row == in_row); k++) step();
        check(tag, qy.size() == 0 && in_n == 0 && out_row == in_row, 1);
    endtask

    initial begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_y      = '0;
        in_u      = '0;
        in_v      = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_rgb", {out_rgb_even, out_rgb_odd}, 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Directed rows streamed back-to-back
        for (int k = 0; k < 6; k++) load_row(k);
        drain("drain_directed");

        // Sink stall mid-row
        load_row(6);
        for (int k = 0; k < 500 && !(out_row == 6 && out_n >= 50); k++) step();
        check("reach_mid_row", out_row == 6 && out_n >= 50, 1);
        hold = 1'b1;
        step();
        check("hold_valid_start", out_valid, 1);
        snap = {out_last, out_rgb_even, out_rgb_odd};
        repeat (4) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_data", {out_last, out_rgb_even, out_rgb_odd}, snap);
            check("hold_in_ready", in_ready, 0);
        end
        hold  = 1'b0;
        p_in  = 70;
        p_out = 70;
        drain("drain_stall");

        // Reset after 37 accepted pairs of a row
        load_row(6);
        p_in  = 80;
        p_out = 80;
        for (int k = 0; k < 1000 && in_n != 37; k++) step();
        check("reach_37", in_n, 37);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        qy.delete();
        qu.delete();
        qv.delete();
        in_row++;
        in_n    = 0;
        out_row = in_row;
        out_n   = 0;

        // Fresh row with random backpressure
        load_row(6);
        p_in  = 60;
        p_out = 75;
        drain("drain_fresh");

        check("t1_first", got[0][0], 48'h0);
        check("t1_final", got[0][P-1], 48'h0);
        check("t2_y235", got[1][0], {G235, G235});
        check("t2_y255", got[2][0], 48'hFF7DFF_FF7DFF);
        check("t3_ramp", got[3][0], 48'h000000_00000A);
        check("t4_row1_end", got[4][P-1], 48'h001E00_001E00);
        check("t4_row2_start", got[5][0], 48'h000091_000091);
        check("rows_done", out_row, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
